// File: rtl/apb_master_bridge.sv
// APB requester: accepts one command, runs an APB SETUP then ACCESS phase, returns a response.
// Latency: response valid two edges after accept with a zero-wait completer (one transfer per 3 cycles).
// Backpressure: an unconsumed response blocks new commands; a stuck completer is aborted after TIMEOUT_CYC waits.
module apb_master_bridge #(
    parameter int ADDR_WD     = 32,
    parameter int DATA_WD     = 32,
    parameter int STRB_WD     = 4,
    parameter int PROT_WD     = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_WD      = 8
) (
    input  logic               b_pclk,
    input  logic               b_prst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_WD-1:0] cmd_addr,
    input  logic [DATA_WD-1:0] cmd_wdata,
    input  logic [STRB_WD-1:0] cmd_strb,
    input  logic [PROT_WD-1:0] cmd_prot,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_WD-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               b_psel,
    output logic               b_penable,
    output logic               b_pwrite,
    output logic [ADDR_WD-1:0] b_paddr,
    output logic [DATA_WD-1:0] b_pwdata,
    output logic [PROT_WD-1:0] b_pprot,
    output logic [STRB_WD-1:0] b_pstrb,
    input  logic [DATA_WD-1:0] b_prdata,
    input  logic               b_pready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Timeout fires when the counter reaches its last allowed wait value.
    localparam bit                TO_EN    = (TIMEOUT_CYC != 0);
    localparam logic [CNT_WD-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_WD'(TIMEOUT_CYC - 1);

    state_t               state_q, state_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [ADDR_WD-1:0]   paddr_q, paddr_d;
    logic [DATA_WD-1:0]   pwdata_q, pwdata_d;
    logic [PROT_WD-1:0]   pprot_q, pprot_d;
    logic [STRB_WD-1:0]   pstrb_q, pstrb_d;
    logic [CNT_WD-1:0]    cnt_q, cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DATA_WD-1:0]   rsp_rdata_q, rsp_rdata_d;

    // A command is taken only in IDLE and only if the response slot is free or being freed now.
    assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready) && !b_prst;

    // Next-state, APB phase sequencing, timeout counting and response loading.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pprot_d     = pprot_q;
        pstrb_d     = pstrb_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        // Consumption clears the slot; a completion below overrides this.
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pprot_d   = cmd_prot;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (b_pready) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : b_prdata;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; an in-flight transfer is simply dropped.
    always_ff @(posedge b_pclk) begin
        if (b_prst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pprot_q     <= '0;
            pstrb_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pprot_q     <= pprot_d;
            pstrb_q     <= pstrb_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign b_psel    = psel_q;
    assign b_penable = penable_q;
    assign b_pwrite  = pwrite_q;
    assign b_paddr   = paddr_q;
    assign b_pwdata  = pwdata_q;
    assign b_pprot   = pprot_q;
    assign b_pstrb   = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
